rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single instruction ROM between two read requesters: the fetch unit (IF) and the load unit (LSU, constant/literal loads from ROM space).
- Sits between the IF/LSU request ports and the ROM pc/inst handshake.
- Performs round-robin arbitration, address legality checks and response routing.
- At most one transaction is outstanding; there is a response timeout.

Parameters:
- ADDR_W, 32, request address width (byte address).
- DATA_W, 32, ROM word width.
- ROM_DEPTH, 128, number of ROM words; the legal word index is 0..ROM_DEPTH-1.
- RSP_TIMEOUT, 15, number of WAIT cycles without a ROM response before an error response is issued.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-high reset. The port name is kept for core-wide consistency; it is asserted high.
- if_req_valid_i  in  1  IF read request.
- if_req_ready_o  out  1  IF request accepted this cycle.
- if_addr_i  in  ADDR_W  IF byte address.
- if_rsp_valid_o  out  1  IF response, one-cycle pulse.
- if_rsp_data_o  out  DATA_W  IF response data.
- if_rsp_err_o  out  1  IF response is an error.
- lsu_req_valid_i, lsu_req_ready_o, lsu_addr_i, lsu_rsp_valid_o, lsu_rsp_data_o, lsu_rsp_err_o  same directions, widths and meaning, for the LSU.
- rom_pc_o  out  ADDR_W  address sent to the ROM.
- rom_pc_valid_o  out  1  ROM request valid.
- rom_pc_ready_i  in  1  ROM can accept a request.
- rom_inst_i  in  DATA_W  ROM data.
- rom_inst_valid_i  in  1  ROM data valid.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - state=IDLE, last_grant=LSU, timeout counter=0.
  - All *_rsp_valid_o, *_rsp_err_o = 0; all *_rsp_data_o = 0.
  - rom_pc_valid_o=0, both req_ready_o=0.
  - Reset mid-transaction discards the outstanding response. No response pulse is emitted for it.
- States: IDLE, WAIT, ERR.
- IDLE arbitration (combinational):
  - Only one requester valid → it is granted.
  - Both valid → grant the requester that is not last_grant.
- IDLE, legal address:
  - rom_pc_o = granted address; rom_pc_valid_o = 1.
  - Granted req_ready_o = rom_pc_ready_i; the non-granted requester's ready = 0.
  - On valid&ready: latch owner, update last_grant, go to WAIT.
- IDLE, illegal address (addr[1:0]!=0 or (addr>>2)>=ROM_DEPTH):
  - rom_pc_valid_o = 0; granted req_ready_o = 1 (accepted unconditionally).
  - Latch owner, update last_grant, go to ERR.
- WAIT:
  - Both req_ready_o = 0; rom_pc_valid_o = 0.
  - rom_inst_valid_i is sampled only in WAIT; a stale high level in other states is ignored.
  - rom_inst_valid_i=1 → next cycle the owner's rsp_valid_o=1, rsp_data_o=rom_inst_i, rsp_err_o=0; go to IDLE.
  - The counter increments each WAIT cycle without a response. Reaching RSP_TIMEOUT → owner gets rsp_valid=1, err=1, data=0; go to IDLE.
- ERR: in the next cycle the owner gets rsp_valid=1, err=1, data=0; go to IDLE.
- Response outputs:
  - Registered, one-cycle pulse, no backpressure; requesters must accept.
  - Data holds its last value between pulses; err clears with valid.
- Latency: request accepted at edge T → ROM data at T+1 → rsp_valid_o high in cycle T+2. A new grant may be accepted in the same cycle the previous response is driven.
- Fairness: under continuous contention grants alternate IF, LSU, IF, and so on. IF wins the first tie after reset.
- The ROM never sees more than one outstanding request.

Optional Feature:
- Macro ROM_ARB_PERF_EN.
- When defined:
  - Adds outputs if_grant_cnt_o, lsu_grant_cnt_o and contention_cnt_o, each 32 bits, saturating at all-ones.
  - The grant counters increment on each accepted request (legal or illegal).
  - contention_cnt_o increments on every cycle where both req_valid are high and a requester is stalled (including cycles spent in WAIT/ERR).
  - All counters reset to 0.
- When undefined: the ports and logic are absent; functional behaviour is identical.

Decomposition:
- Shared defines/package:
  - PORT_WORD_WIDTH-style width macros for ADDR_W/DATA_W.
  - State encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_ERR=2'd2.
  - Requester IDs REQ_IF=1'b0, REQ_LSU=1'b1.
  - Enable/disable constants.
- One sub-module, rom_arb_rr: a 2-way round-robin picker.
  - Inputs: two valids and last_grant.
  - Outputs: a one-hot grant.
  - Purely combinational; last_grant stays in rom_arbiter.

Test Plan:
- Single IF read of addr 0x08; ROM returns 0x00A00093 the cycle after acceptance → if_rsp_valid_o pulses once at T+2 with data 0x00A00093, err=0; LSU outputs stay 0.
- IF and LSU both valid continuously for 6 accepts with rom_pc_ready_i=1 → grant order IF, LSU, IF, LSU, IF, LSU; each response is routed to the matching port.
- LSU addr 0x202 (misaligned) and then 0x200 (index 128, out of range) → each accepted without a ROM request; lsu_rsp_valid=1, err=1, data=0 one cycle later.
- ROM never asserts rom_inst_valid_i after an IF accept → after 15 WAIT cycles if_rsp_valid=1, err=1; state returns to IDLE and the next LSU request is served normally.
- rom_pc_ready_i=0 for 3 cycles with IF valid → if_req_ready_o stays 0 and rom_pc_valid_o/rom_pc_o are held stable; the accept happens on the first ready cycle.
- Reset asserted in WAIT → no response pulse, all outputs 0, and the next tie is granted to IF; with ROM_ARB_PERF_EN defined, the counters read 0.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared widths, state/requester encodings and helpers for the ROM arbiter.
package rom_arbiter_pkg;

  localparam int unsigned PORT_ADDR_W = 32;
  localparam int unsigned PORT_DATA_W = 32;
  localparam int unsigned PERF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam logic EN  = 1'b1;
  localparam logic DIS = 1'b0;

  // Saturating increment for the performance counters.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rom_arbiter_rr.sv
// Two-way round-robin picker; one-hot grant indexed by REQ_IF / REQ_LSU.
module rom_arb_rr
  import rom_arbiter_pkg::*;
(
  input  logic       if_valid,
  input  logic       lsu_valid,
  input  logic       last_grant,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = '0;
    if (if_valid && lsu_valid) begin
      // Tie goes to whoever did not win last time.
      if (last_grant == REQ_LSU) gnt_c[REQ_IF]  = EN;
      else                       gnt_c[REQ_LSU] = EN;
    end else if (if_valid) begin
      gnt_c[REQ_IF] = EN;
    end else if (lsu_valid) begin
      gnt_c[REQ_LSU] = EN;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the instruction ROM between IF and LSU: round-robin grant, address
// legality, single outstanding request with timeout. Optional counters: ROM_ARB_PERF_EN.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = PORT_ADDR_W,
  parameter int unsigned DATA_W      = PORT_DATA_W,
  parameter int unsigned ROM_DEPTH   = 128,
  parameter int unsigned RSP_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_rsp_valid_o,
  output logic [DATA_W-1:0] if_rsp_data_o,
  output logic              if_rsp_err_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  output logic              lsu_rsp_valid_o,
  output logic [DATA_W-1:0] lsu_rsp_data_o,
  output logic              lsu_rsp_err_o,
  output logic [ADDR_W-1:0] rom_pc_o,
  output logic              rom_pc_valid_o,
  input  logic              rom_pc_ready_i,
  input  logic [DATA_W-1:0] rom_inst_i,
  input  logic              rom_inst_valid_i
`ifdef ROM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] if_grant_cnt_o,
  output logic [PERF_CNT_W-1:0] lsu_grant_cnt_o,
  output logic [PERF_CNT_W-1:0] contention_cnt_o
`endif
);

  localparam int unsigned TO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  state_e            state;
  logic              last_grant;
  logic              owner;
  logic [TO_W-1:0]   to_cnt;

  logic [1:0]        gnt_c;
  logic              gnt_id_c;
  logic              any_gnt_c;
  logic [ADDR_W-1:0] gnt_addr_c;
  logic              addr_ok_c;
  logic              accept_c;
  logic              rsp_fire_c;
  logic              rsp_err_c;
  logic [DATA_W-1:0] rsp_data_c;

  rom_arb_rr u_rr (
    .if_valid   (if_req_valid_i),
    .lsu_valid  (lsu_req_valid_i),
    .last_grant (last_grant),
    .gnt_c      (gnt_c)
  );

  // Request side: grant mux, legality check and handshake.
  always_comb begin
    gnt_id_c        = gnt_c[REQ_LSU];
    any_gnt_c       = |gnt_c;
    gnt_addr_c      = (gnt_id_c == REQ_LSU) ? lsu_addr_i : if_addr_i;
    addr_ok_c       = (gnt_addr_c[1:0] == 2'b00) &&
                      ((gnt_addr_c >> 2) < ADDR_W'(ROM_DEPTH));
    rom_pc_o        = gnt_addr_c;
    rom_pc_valid_o  = DIS;
    if_req_ready_o  = DIS;
    lsu_req_ready_o = DIS;
    accept_c        = DIS;
    if (state == ST_IDLE && any_gnt_c) begin
      // Illegal addresses never reach the ROM and are taken unconditionally.
      rom_pc_valid_o = addr_ok_c;
      accept_c       = addr_ok_c ? rom_pc_ready_i : EN;
      if (gnt_id_c == REQ_LSU) lsu_req_ready_o = accept_c;
      else                     if_req_ready_o  = accept_c;
    end
  end

  // Response side: ROM data, timeout or early error.
  always_comb begin
    rsp_fire_c = DIS;
    rsp_err_c  = DIS;
    rsp_data_c = '0;
    case (state)
      ST_WAIT: begin
        if (rom_inst_valid_i) begin
          rsp_fire_c = EN;
          rsp_data_c = rom_inst_i;
        end else if (to_cnt == TO_W'(RSP_TIMEOUT - 1)) begin
          rsp_fire_c = EN;
          rsp_err_c  = EN;
        end
      end
      ST_ERR: begin
        rsp_fire_c = EN;
        rsp_err_c  = EN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state           <= ST_IDLE;
      last_grant      <= REQ_LSU;
      owner           <= REQ_IF;
      to_cnt          <= '0;
      if_rsp_valid_o  <= 1'b0;
      if_rsp_err_o    <= 1'b0;
      if_rsp_data_o   <= '0;
      lsu_rsp_valid_o <= 1'b0;
      lsu_rsp_err_o   <= 1'b0;
      lsu_rsp_data_o  <= '0;
    end else begin
      if_rsp_valid_o  <= 1'b0;
      if_rsp_err_o    <= 1'b0;
      lsu_rsp_valid_o <= 1'b0;
      lsu_rsp_err_o   <= 1'b0;
      if (rsp_fire_c) begin
        if (owner == REQ_LSU) begin
          lsu_rsp_valid_o <= 1'b1;
          lsu_rsp_err_o   <= rsp_err_c;
          lsu_rsp_data_o  <= rsp_data_c;
        end else begin
          if_rsp_valid_o <= 1'b1;
          if_rsp_err_o   <= rsp_err_c;
          if_rsp_data_o  <= rsp_data_c;
        end
      end
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            owner      <= gnt_id_c;
            last_grant <= gnt_id_c;
            to_cnt     <= '0;
            state      <= addr_ok_c ? ST_WAIT : ST_ERR;
          end
        end
        ST_WAIT: begin
          if (rsp_fire_c) begin
            to_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROM_ARB_PERF_EN
  // Any cycle with both requesters valid leaves one of them stalled.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if_grant_cnt_o   <= '0;
      lsu_grant_cnt_o  <= '0;
      contention_cnt_o <= '0;
    end else begin
      if (accept_c && gnt_id_c == REQ_IF)  if_grant_cnt_o  <= sat_inc(if_grant_cnt_o);
      if (accept_c && gnt_id_c == REQ_LSU) lsu_grant_cnt_o <= sat_inc(lsu_grant_cnt_o);
      if (if_req_valid_i && lsu_req_valid_i) contention_cnt_o <= sat_inc(contention_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: transaction-level reference model checked every
// cycle, plus literal expectations per scenario. Honors ROM_ARB_PERF_EN.
module tb_rom_arbiter;

  localparam int unsigned ROM_DEPTH   = 128;
  localparam int unsigned RSP_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req_valid = 1'b0, lsu_req_valid = 1'b0;
  logic [31:0] if_addr = '0, lsu_addr = '0;
  logic        rom_pc_ready = 1'b1;
  logic [31:0] rom_inst;
  logic        rom_inst_valid;
  logic        if_req_ready_o, lsu_req_ready_o, rom_pc_valid_o;
  logic        if_rsp_valid_o, if_rsp_err_o, lsu_rsp_valid_o, lsu_rsp_err_o;
  logic [31:0] if_rsp_data_o, lsu_rsp_data_o, rom_pc_o;
`ifdef ROM_ARB_PERF_EN
  logic [31:0] if_gc, lsu_gc, cont_c;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit rom_silent = 1'b0;

  always #5 clk = ~clk;

  rom_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req_valid_i   (if_req_valid),
    .if_req_ready_o   (if_req_ready_o),
    .if_addr_i        (if_addr),
    .if_rsp_valid_o   (if_rsp_valid_o),
    .if_rsp_data_o    (if_rsp_data_o),
    .if_rsp_err_o     (if_rsp_err_o),
    .lsu_req_valid_i  (lsu_req_valid),
    .lsu_req_ready_o  (lsu_req_ready_o),
    .lsu_addr_i       (lsu_addr),
    .lsu_rsp_valid_o  (lsu_rsp_valid_o),
    .lsu_rsp_data_o   (lsu_rsp_data_o),
    .lsu_rsp_err_o    (lsu_rsp_err_o),
    .rom_pc_o         (rom_pc_o),
    .rom_pc_valid_o   (rom_pc_valid_o),
    .rom_pc_ready_i   (rom_pc_ready),
    .rom_inst_i       (rom_inst),
    .rom_inst_valid_i (rom_inst_valid)
`ifdef ROM_ARB_PERF_EN
    ,
    .if_grant_cnt_o   (if_gc),
    .lsu_grant_cnt_o  (lsu_gc),
    .contention_cnt_o (cont_c)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h00A00093;
    return 32'hC0DE_0000 ^ a;
  endfunction

  // ROM stand-in: answers one cycle after each accepted pc unless silenced.
  initial begin
    logic        fire;
    logic [31:0] pc;
    rom_inst_valid = 1'b0;
    rom_inst       = '0;
    forever begin
      @(negedge clk);
      fire = (rom_pc_valid_o === 1'b1) && rom_pc_ready;
      pc   = rom_pc_o;
      @(posedge clk);
      #1;
      rom_inst_valid = fire && !rom_silent;
      rom_inst       = fire ? rom_word(pc) : 32'hDEAD_BEEF;
    end
  end

  // Reference model: one pending transaction, tracked by owner and cycles waited.
  bit          m_known = 1'b0;
  bit          m_busy, m_err, m_owner, m_last;
  int          m_waited;
  logic [31:0] m_word;
  logic        m_if_v, m_if_e, m_lsu_v, m_lsu_e;
  logic [31:0] m_if_d, m_lsu_d;
  int          m_if_gc, m_lsu_gc, m_cont;
  bit          grant_log[$];

  always @(negedge clk) begin : model
    bit          g, any, legal, acc, pcv, fire, err;
    logic [31:0] ga;
    any   = if_req_valid || lsu_req_valid;
    g     = (if_req_valid && lsu_req_valid) ? !m_last : lsu_req_valid;
    ga    = g ? lsu_addr : if_addr;
    legal = (ga % 4 == 0) && (ga / 4 < ROM_DEPTH);
    acc   = !m_busy && any && (!legal || rom_pc_ready);
    pcv   = !m_busy && any && legal;
    if (m_known) begin
      chk("if_req_ready", if_req_ready_o, acc && !g);
      chk("lsu_req_ready", lsu_req_ready_o, acc && g);
      chk("rom_pc_valid", rom_pc_valid_o, pcv);
      if (pcv) chk("rom_pc", rom_pc_o, ga);
      chk("if_rsp_valid", if_rsp_valid_o, m_if_v);
      chk("if_rsp_err", if_rsp_err_o, m_if_e);
      chk("if_rsp_data", if_rsp_data_o, m_if_d);
      chk("lsu_rsp_valid", lsu_rsp_valid_o, m_lsu_v);
      chk("lsu_rsp_err", lsu_rsp_err_o, m_lsu_e);
      chk("lsu_rsp_data", lsu_rsp_data_o, m_lsu_d);
`ifdef ROM_ARB_PERF_EN
      chk("if_grant_cnt", if_gc, 32'(m_if_gc));
      chk("lsu_grant_cnt", lsu_gc, 32'(m_lsu_gc));
      chk("contention_cnt", cont_c, 32'(m_cont));
`endif
    end
    if (rst_n) begin
      m_known = 1'b1; m_busy = 1'b0; m_err = 1'b0; m_owner = 1'b0; m_last = 1'b1;
      m_waited = 0; m_word = '0;
      m_if_v = 0; m_if_e = 0; m_if_d = '0; m_lsu_v = 0; m_lsu_e = 0; m_lsu_d = '0;
      m_if_gc = 0; m_lsu_gc = 0; m_cont = 0;
      grant_log.delete();
    end else begin
      m_if_v = 0; m_if_e = 0; m_lsu_v = 0; m_lsu_e = 0;
      fire = 1'b0; err = 1'b0;
      if (m_busy) begin
        if (m_err) begin fire = 1'b1; err = 1'b1; end
        else if (rom_inst_valid) fire = 1'b1;
        else if (m_waited + 1 >= RSP_TIMEOUT) begin fire = 1'b1; err = 1'b1; end
        else m_waited++;
        if (fire) begin
          m_busy = 1'b0;
          if (m_owner) begin m_lsu_v = 1; m_lsu_e = err; m_lsu_d = err ? '0 : m_word; end
          else begin m_if_v = 1; m_if_e = err; m_if_d = err ? '0 : m_word; end
        end
      end else if (acc) begin
        m_busy = 1'b1; m_err = !legal; m_owner = g; m_last = g; m_waited = 0;
        m_word = rom_word(ga);
        grant_log.push_back(g);
        if (g) m_lsu_gc++; else m_if_gc++;
      end
      if (if_req_valid && lsu_req_valid) m_cont++;
    end
  end

  task automatic request(input bit is_lsu, input logic [31:0] a);
    bit done = 1'b0;
    @(posedge clk); #1;
    if (is_lsu) begin lsu_req_valid = 1'b1; lsu_addr = a; end
    else begin if_req_valid = 1'b1; if_addr = a; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = ((is_lsu ? lsu_req_ready_o : if_req_ready_o) === 1'b1);
    end
    @(posedge clk); #1;
    if (is_lsu) lsu_req_valid = 1'b0; else if_req_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL accept_wait: port %0d addr %0h never accepted", is_lsu, a);
    end
  endtask

  // Returns the number of negedges until the response pulse (0 if none within bound).
  task automatic wait_rsp(input bit is_lsu, output int n);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      if ((is_lsu ? lsu_rsp_valid_o : if_rsp_valid_o) === 1'b1) n = i;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          n, nacc;
    logic        g_if, g_lsu;
    logic [5:0]  order;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_if_rsp_valid", if_rsp_valid_o, 0);
    chk("reset_if_rsp_data", if_rsp_data_o, 0);
    chk("reset_lsu_rsp_err", lsu_rsp_err_o, 0);
    chk("reset_lsu_rsp_data", lsu_rsp_data_o, 0);
    chk("reset_rom_pc_valid", rom_pc_valid_o, 0);
    chk("reset_ready", {if_req_ready_o, lsu_req_ready_o}, 0);

    // Single IF read.
    request(1'b0, 32'h8);
    wait_rsp(1'b0, n);
    chk("t1_latency", n, 2);
    chk("t1_data", if_rsp_data_o, 32'h00A00093);
    chk("t1_err", if_rsp_err_o, 0);
    chk("t1_lsu_quiet", {lsu_rsp_valid_o, lsu_rsp_err_o, lsu_rsp_data_o}, 0);
    @(negedge clk);
    chk("t1_pulse_width", if_rsp_valid_o, 0);

    // Illegal LSU addresses, then the last legal word.
    request(1'b1, 32'h202);
    wait_rsp(1'b1, n);
    chk("t3_misaligned_latency", n, 2);
    chk("t3_misaligned_rsp", {lsu_rsp_err_o, lsu_rsp_data_o}, {1'b1, 32'h0});
    request(1'b1, 32'h200);
    wait_rsp(1'b1, n);
    chk("t3_range_latency", n, 2);
    chk("t3_range_rsp", {lsu_rsp_err_o, lsu_rsp_data_o}, {1'b1, 32'h0});
    request(1'b1, 32'h1FC);
    wait_rsp(1'b1, n);
    chk("t3_last_word", {lsu_rsp_err_o, lsu_rsp_data_o}, {1'b0, 32'hC0DE_01FC});

    // Continuous contention: six alternating grants, IF first.
    @(posedge clk); #1;
    grant_log.delete();
    if_addr = 32'h0; lsu_addr = 32'h100;
    if_req_valid = 1'b1; lsu_req_valid = 1'b1;
    nacc = 0;
    for (int c = 0; c < 100 && nacc < 6; c++) begin
      @(negedge clk);
      g_if = (if_req_ready_o === 1'b1);
      g_lsu = (lsu_req_ready_o === 1'b1);
      if (g_if || g_lsu) begin
        chk("t2_grant_is_lsu", g_lsu, 64'(nacc % 2));
        nacc++;
      end
      @(posedge clk); #1;
      if (g_if) if_addr += 32'h4;
      if (g_lsu) lsu_addr += 32'h4;
      if (nacc == 6) begin if_req_valid = 1'b0; lsu_req_valid = 1'b0; end
    end
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    chk("t2_accepts", nacc, 6);
    wait_rsp(1'b1, n);
    chk("t2_last_latency", n, 2);
    chk("t2_last_data", lsu_rsp_data_o, 32'hC0DE_0108);
    chk("t2_model_log_len", grant_log.size(), 6);
    order = '0;
    for (int i = 0; i < 6 && i < grant_log.size(); i++) order[i] = grant_log[i];
    chk("t2_model_order", order, 6'b101010);

    // Silent ROM: timeout error, then a normal LSU read.
    rom_silent = 1'b1;
    request(1'b0, 32'h10);
    wait_rsp(1'b0, n);
    rom_silent = 1'b0;
    chk("t4_timeout_latency", n, 16);
    chk("t4_timeout_rsp", {if_rsp_err_o, if_rsp_data_o}, {1'b1, 32'h0});
    request(1'b1, 32'h14);
    wait_rsp(1'b1, n);
    chk("t4_after_latency", n, 2);
    chk("t4_after_rsp", {lsu_rsp_err_o, lsu_rsp_data_o}, {1'b0, 32'hC0DE_0014});

    // ROM backpressure for three cycles.
    @(posedge clk); #1;
    rom_pc_ready = 1'b0; if_req_valid = 1'b1; if_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_ready", if_req_ready_o, 0);
      chk("t5_stall_pc", {rom_pc_valid_o, rom_pc_o}, {1'b1, 32'h20});
      @(posedge clk); #1;
    end
    rom_pc_ready = 1'b1;
    @(negedge clk);
    chk("t5_accept", if_req_ready_o, 1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    wait_rsp(1'b0, n);
    chk("t5_latency", n, 2);

    // Reset while waiting on the ROM.
    request(1'b0, 32'h24);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_pulse", {if_rsp_valid_o, lsu_rsp_valid_o, if_rsp_err_o, lsu_rsp_err_o}, 0);
    end
    chk("t6_data_cleared", {if_rsp_data_o, lsu_rsp_data_o}, 0);
`ifdef ROM_ARB_PERF_EN
    chk("t6_counters_zero", {if_gc, lsu_gc, cont_c}, 0);
`endif
    @(posedge clk); #1;
    if_req_valid = 1'b1; lsu_req_valid = 1'b1; if_addr = 32'h28; lsu_addr = 32'h2C;
    @(negedge clk);
    chk("t6_tie_to_if", {if_req_ready_o, lsu_req_ready_o}, 2'b10);
    @(posedge clk); #1;
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    wait_rsp(1'b0, n);
    chk("t6_after_reset_data", {n[7:0], if_rsp_data_o}, {8'd2, 32'hC0DE_0028});

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
